// File: rtl/term_port_arbiter.sv
// Round-robin arbiter that takes N_SRC source FIFOs into one mesh terminal port.
// Define BDCST_PRIO_EN to give broadcast-ID packets priority over the others.
module term_port_arbiter #(
    parameter int unsigned pckg_sz = 16,
    parameter int unsigned N_SRC   = 4,
    parameter logic [7:0]  bdcst   = {8{1'b1}}
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [N_SRC-1:0]                 src_pndng,
    input  logic [N_SRC-1:0][pckg_sz-1:0]    src_data,
    output logic [N_SRC-1:0]                 src_pop,
    output logic                             pndng_i_in,
    output logic [pckg_sz-1:0]               data_out_i_in,
    input  logic                             popin,
    output logic [$clog2(N_SRC)-1:0]         gnt_id,
    output logic [15:0]                      pkt_cnt
);

    localparam int unsigned ID_W = $clog2(N_SRC);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_SRC - 1);

    typedef enum logic {
        IDLE,
        OFFER
    } state_t;

    state_t               state_q, state_d;
    logic [N_SRC-1:0]     src_pop_q, src_pop_d;
    logic                 pndng_q, pndng_d;
    logic [pckg_sz-1:0]   data_q, data_d;
    logic [ID_W-1:0]      gnt_q, gnt_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [ID_W-1:0]      rr_q, rr_d;

    logic [N_SRC-1:0]     eligible;
    logic [ID_W-1:0]      win;
    int unsigned          idx;
`ifdef BDCST_PRIO_EN
    logic [N_SRC-1:0]     is_bc;
`endif

    // The search runs from the furthest offset down so the nearest requester
    // at or after rr_q is the last one assigned and wins.
    always_comb begin
        eligible = src_pndng;
`ifdef BDCST_PRIO_EN
        is_bc = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            is_bc[i] = src_pndng[i] && (src_data[i][pckg_sz-1 -: 8] == bdcst);
        end
        if (|is_bc) begin
            eligible = is_bc;
        end
`endif
        win = '0;
        idx = 0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            idx = 32'(rr_q) + (N_SRC - 1 - k);
            if (idx >= N_SRC) begin
                idx = idx - N_SRC;
            end
            if (eligible[ID_W'(idx)]) begin
                win = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        src_pop_d = '0;
        pndng_d   = pndng_q;
        data_d    = data_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        rr_d      = rr_q;
        unique case (state_q)
            IDLE: begin
                if (|src_pndng) begin
                    data_d         = src_data[win];
                    gnt_d          = win;
                    src_pop_d[win] = 1'b1;
                    pndng_d        = 1'b1;
                    state_d        = OFFER;
                end
            end
            OFFER: begin
                if (popin) begin
                    pndng_d = 1'b0;
                    cnt_d   = cnt_q + 16'd1;
                    rr_d    = (gnt_q == LAST_ID) ? '0 : gnt_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            src_pop_q <= '0;
            pndng_q   <= 1'b0;
            data_q    <= '0;
            gnt_q     <= '0;
            cnt_q     <= '0;
            rr_q      <= '0;
        end else begin
            state_q   <= state_d;
            src_pop_q <= src_pop_d;
            pndng_q   <= pndng_d;
            data_q    <= data_d;
            gnt_q     <= gnt_d;
            cnt_q     <= cnt_d;
            rr_q      <= rr_d;
        end
    end

    assign src_pop       = src_pop_q;
    assign pndng_i_in    = pndng_q;
    assign data_out_i_in = data_q;
    assign gnt_id        = gnt_q;
    assign pkt_cnt       = cnt_q;

endmodule

// File: tb/tb_term_port_arbiter.sv
// Directed bench for term_port_arbiter (N_SRC=4, 16-bit packets);
// expected broadcast ordering follows BDCST_PRIO_EN.
module tb_term_port_arbiter;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       src_pndng;
    logic [3:0][15:0] src_data;
    logic [3:0]       src_pop;
    logic             pndng_i_in;
    logic [15:0]      data_out_i_in;
    logic             popin;
    logic [1:0]       gnt_id;
    logic [15:0]      pkt_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    term_port_arbiter #(
        .pckg_sz(16),
        .N_SRC  (4),
        .bdcst  (8'hFF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .src_pndng    (src_pndng),
        .src_data     (src_data),
        .src_pop      (src_pop),
        .pndng_i_in   (pndng_i_in),
        .data_out_i_in(data_out_i_in),
        .popin        (popin),
        .gnt_id       (gnt_id),
        .pkt_cnt      (pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] first_id;
        logic [1:0] second_id;

        reset     = 1'b1;
        src_pndng = 4'b0000;
        src_data  = '0;
        popin     = 1'b0;
        step();
        step();
        check("rst_pndng", 32'(pndng_i_in), 32'd0);
        check("rst_pop",   32'(src_pop), 32'd0);
        check("rst_data",  32'(data_out_i_in), 32'd0);
        check("rst_gnt",   32'(gnt_id), 32'd0);
        check("rst_cnt",   32'(pkt_cnt), 32'd0);

        // single request, granted on the first edge after release
        reset       = 1'b0;
        src_pndng   = 4'b0100;
        src_data[2] = 16'h12AB;
        popin       = 1'b1;
        step();
        check("single_pop",   32'(src_pop), 32'h4);
        check("single_data",  32'(data_out_i_in), 32'h12AB);
        check("single_gnt",   32'(gnt_id), 32'd2);
        check("single_pndng", 32'(pndng_i_in), 32'd1);
        src_pndng = 4'b0000;
        step();
        check("single_pop_off",   32'(src_pop), 32'd0);
        check("single_pndng_off", 32'(pndng_i_in), 32'd0);
        check("single_cnt",       32'(pkt_cnt), 32'd1);
        step();
        check("idle_hold_data", 32'(data_out_i_in), 32'h12AB);
        check("idle_hold_cnt",  32'(pkt_cnt), 32'd1);

        // long hold: rr_ptr=3, source 0 only; src_pndng stays high and is ignored
        popin       = 1'b0;
        src_pndng   = 4'b0001;
        src_data[0] = 16'hBEEF;
        step();
        check("hold_gnt",   32'(gnt_id), 32'd0);
        check("hold_pop",   32'(src_pop), 32'h1);
        check("hold_pndng", 32'(pndng_i_in), 32'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            check("hold_pndng_cyc", 32'(pndng_i_in), 32'd1);
            check("hold_data_cyc",  32'(data_out_i_in), 32'hBEEF);
            check("hold_pop_cyc",   32'(src_pop), 32'd0);
        end
        popin     = 1'b1;
        src_pndng = 4'b0000;
        step();
        check("hold_release", 32'(pndng_i_in), 32'd0);
        check("hold_cnt",     32'(pkt_cnt), 32'd2);

        // reset during the third OFFER cycle
        popin       = 1'b0;
        src_pndng   = 4'b0010;
        src_data[1] = 16'h5555;
        step();
        step();
        step();
        check("pre_rst_pndng", 32'(pndng_i_in), 32'd1);
        reset = 1'b1;
        #1;
        check("async_rst_pndng", 32'(pndng_i_in), 32'd0);
        check("async_rst_data",  32'(data_out_i_in), 32'd0);
        check("async_rst_gnt",   32'(gnt_id), 32'd0);
        check("async_rst_cnt",   32'(pkt_cnt), 32'd0);
        check("async_rst_pop",   32'(src_pop), 32'd0);
        src_pndng = 4'b0000;
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_pndng", 32'(pndng_i_in), 32'd0);
            check("post_rst_pop",   32'(src_pop), 32'd0);
            check("post_rst_cnt",   32'(pkt_cnt), 32'd0);
        end

        // all four requesting: rotation 0,1,2,3,0 at one grant per two cycles
        for (int i = 0; i < 4; i++) src_data[i] = 16'hA000 + 16'(i);
        src_pndng = 4'b1111;
        popin     = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("rr_gnt",   32'(gnt_id), 32'(k % 4));
            check("rr_pop",   32'(src_pop), 32'(1 << (k % 4)));
            check("rr_data",  32'(data_out_i_in), 32'hA000 + 32'(k % 4));
            check("rr_pndng", 32'(pndng_i_in), 32'd1);
            step();
            check("rr_gap_pndng", 32'(pndng_i_in), 32'd0);
            check("rr_gap_pop",   32'(src_pop), 32'd0);
            check("rr_cnt",       32'(pkt_cnt), 32'(k + 1));
        end

        // popin while idle does nothing
        src_pndng = 4'b0000;
        step();
        step();
        check("idle_popin_cnt",   32'(pkt_cnt), 32'd5);
        check("idle_popin_pndng", 32'(pndng_i_in), 32'd0);

        // bring rr_ptr back to 0 by granting source 3
        src_pndng = 4'b1000;
        step();
        check("wrap_gnt3", 32'(gnt_id), 32'd3);
        src_pndng = 4'b0000;
        step();
        check("wrap_cnt6", 32'(pkt_cnt), 32'd6);

        // broadcast ordering: src 1 carries the broadcast ID
        src_data[1] = 16'hFF05;
        src_data[0] = 16'h0305;
`ifdef BDCST_PRIO_EN
        first_id  = 2'd1;
        second_id = 2'd0;
`else
        first_id  = 2'd0;
        second_id = 2'd1;
`endif
        src_pndng = 4'b0011;
        step();
        check("bc_first_gnt", 32'(gnt_id), 32'(first_id));
        src_pndng[first_id] = 1'b0;
        step();
        step();
        check("bc_second_gnt",  32'(gnt_id), 32'(second_id));
        check("bc_second_data", 32'(data_out_i_in), (second_id == 2'd1) ? 32'hFF05 : 32'h0305);
        src_pndng = 4'b0000;
        step();
        check("bc_cnt", 32'(pkt_cnt), 32'd8);

        // counter wrap from 16'hFFFF
        force dut.cnt_q = 16'hFFFE;
        #1;
        release dut.cnt_q;
        #1;
        check("cnt_preset", 32'(pkt_cnt), 32'hFFFE);
        src_pndng = 4'b0100;
        step();
        src_pndng = 4'b0000;
        step();
        check("cnt_ffff", 32'(pkt_cnt), 32'hFFFF);
        src_pndng = 4'b0100;
        step();
        src_pndng = 4'b0000;
        step();
        check("cnt_wrap", 32'(pkt_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/term_port_arbiter.md
TERM_PORT_ARBITER -- requirements
Module: term_port_arbiter

Interface
REQ-001 Parameter pckg_sz, default 16: width of one packet in bits.
REQ-002 Parameter N_SRC, default 4: number of requesting source FIFOs; legal range 2..16.
REQ-003 Parameter bdcst, default {8{1'b1}}: broadcast ID value, compared against packet bits [pckg_sz-1 -: 8].
REQ-004 Port clk  in  1: single clock; all state updates on its rising edge.
REQ-005 Port reset  in  1: asynchronous, active-high reset.
REQ-006 Port src_pndng  in  N_SRC: bit i high = source FIFO i holds at least one packet.
REQ-007 Port src_data  in  N_SRC x pckg_sz: head packet of each source FIFO.
REQ-008 Port src_pop  out  N_SRC: one-cycle pop strobe to source FIFO i.
REQ-009 Port pndng_i_in  out  1: packet available to the mesh terminal.
REQ-010 Port data_out_i_in  out  pckg_sz: packet offered to the mesh terminal.
REQ-011 Port popin  in  1: mesh terminal accepts the offered packet.
REQ-012 Port gnt_id  out  $clog2(N_SRC): index of the source that owns the current packet.
REQ-013 Port pkt_cnt  out  16: count of packets accepted by the terminal.

Function
REQ-014 FSM states: IDLE, OFFER.
REQ-015 IDLE, no src_pndng bit set: remain in IDLE; all outputs hold.
REQ-016 IDLE, any src_pndng bit set:
- Select winner w, round-robin, searching from rr_ptr upward with wrap.
- On next edge: data_out_i_in <= src_data[w]; gnt_id <= w; src_pop[w] <= 1 for exactly one cycle; pndng_i_in <= 1; state <= OFFER.
REQ-017 Latency: pndng_i_in rises on the first edge after the request is sampled in IDLE.
REQ-018 OFFER:
- data_out_i_in and gnt_id held stable.
- pndng_i_in held high until popin is sampled high.
- src_pndng ignored.
REQ-019 OFFER with popin high on an edge:
- pndng_i_in <= 0; state <= IDLE; pkt_cnt <= pkt_cnt+1; rr_ptr <= (w+1) mod N_SRC.
REQ-020 popin sampled high while in IDLE has no effect.
REQ-021 pkt_cnt wraps from 16'hFFFF to 0.
REQ-022 At most one src_pop bit is high in any cycle; src_pop is never high while in IDLE.
REQ-023 Throughput: at most one packet per 2 cycles; IDLE always lasts at least one cycle between packets so the popped FIFO's pndng is current.

Reset
REQ-024 reset high, asynchronously:
- state <= IDLE; src_pop <= 0; pndng_i_in <= 0; data_out_i_in <= 0; gnt_id <= 0; pkt_cnt <= 0; rr_ptr <= 0.
REQ-025 Reset while in OFFER: the held packet is discarded; the source is not re-popped and pkt_cnt is not incremented.
REQ-026 First grant after reset release: the earliest edge with reset low.

Configuration
REQ-027 Macro BDCST_PRIO_EN, defined:
- In IDLE, sources whose head packet has bits [pckg_sz-1 -: 8] equal to bdcst win over non-broadcast sources.
- Round-robin order from rr_ptr applies within the broadcast subset.
- A broadcast grant still advances rr_ptr per REQ-019.
REQ-028 Macro BDCST_PRIO_EN, undefined: pure round-robin per REQ-016; packet contents do not affect arbitration.

Verification
REQ-029 src_pndng=4'b0100, src_data[2]=16'h12AB, popin held 1 -> src_pop=4'b0100 for one cycle; data_out_i_in=16'h12AB; gnt_id=2; pndng_i_in high one cycle; pkt_cnt=1.
REQ-030 src_pndng=4'b1111 held, popin held 1 -> gnt_id sequence 0,1,2,3,0; one grant per 2 cycles; pkt_cnt=5.
REQ-031 Single request, popin low for 10 cycles then high -> pndng_i_in high for 11 cycles; data stable throughout; src_pop pulsed once.
REQ-032 reset asserted in the third OFFER cycle -> all outputs 0 immediately; after release with src_pndng=0, pndng_i_in stays 0 and pkt_cnt=0.
REQ-033 BDCST_PRIO_EN defined, rr_ptr=0, src_pndng=4'b0011, src_data[1]=16'hFF05, src_data[0]=16'h0305 -> gnt_id=1 first, then 0; macro undefined -> 0 first, then 1.
REQ-034 pkt_cnt preset to 16'hFFFF via 65535 accepted packets, one more accepted -> pkt_cnt=0.
